// File: rtl/pio_share_arbiter_pkg.sv
// Shared definitions for the PIO share arbiter: register map, owner encoding,
// LOCK bit position and port index helpers.
package pio_arb_pkg;

    // Register word addresses
    localparam int ADDR_DATA   = 0;
    localparam int ADDR_LOCK   = 1;
    localparam int ADDR_STATUS = 2;

    // Bit of a LOCK write carrying the acquire (1) / release (0) command
    localparam int LOCK_BIT = 0;

    // Index of each port in the request/grant vectors
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // Owner of the DATA register; the encoding is what LOCK reads back
    typedef enum logic [1:0] {
        OWN_FREE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    // Owner code that corresponds to the port performing an access
    function automatic owner_e port_owner(input logic is_b);
        return is_b ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/pio_share_arbiter_if.sv
// Avalon-MM style slave port bundle: one instance per master sharing the PIO.
interface pio_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, writedata, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pio_share_arbiter_rr_arbiter2.sv
// Two-request round-robin arbiter. When both ports request, the one that was
// not granted last wins; a lone requester always wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    // 0: port a was granted last, 1: port b was granted last
    logic last_grant;

    // Grant selection from current requests and the rotation pointer
    always_comb begin
        // NOTE: grant gets a default before the case so every path assigns it; no latch is inferred.
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Rotation pointer: remembers the winner of every granted cycle
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        // Reset points at b so that a is favoured on the first contended cycle.
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant != 2'b00) begin
            last_grant <= grant[1];
        end
    end
endmodule

// File: rtl/pio_share_arbiter.sv
// Shares one PIO output register between two slave ports. One granted access
// per cycle; the loser stalls via waitrequest. An ownership lock lets one port
// own DATA, and refused DATA/LOCK operations are counted in a saturating
// conflict counter.
module pio_share_arbiter
    import pio_arb_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 4,
    parameter int              CNT_W       = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_share_arbiter_if.slave   port_a,
    pio_share_arbiter_if.slave   port_b,
    output logic [DATA_W-1:0]    pio_out
);
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [DATA_W-1:0] data_q;
    owner_e            owner_q;
    logic [CNT_W-1:0]  conflict_q;

    // Granted access, decoded
    logic              acc_write;
    logic              acc_is_b;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    owner_e            acc_owner;
    logic              data_wr;
    logic              lock_wr;
    logic              status_wr;
    logic              data_allowed;
    logic              conflict_inc;
    logic [DATA_W-1:0] rd_value;

    assign req = {port_b.write | port_b.read, port_a.write | port_a.read};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign port_a.waitrequest = req[PORT_A] & ~grant[PORT_A];
    assign port_b.waitrequest = req[PORT_B] & ~grant[PORT_B];

    // Select the granted port's access and decode its effect on the registers
    always_comb begin
        acc_is_b  = grant[PORT_B];
        acc_write = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        if (grant[PORT_A]) begin
            acc_write = port_a.write;
            acc_addr  = port_a.address;
            acc_wdata = port_a.writedata;
        end else if (grant[PORT_B]) begin
            acc_write = port_b.write;
            acc_addr  = port_b.address;
            acc_wdata = port_b.writedata;
        end
        acc_owner    = port_owner(acc_is_b);
        data_wr      = acc_write && (acc_addr == ADDR_W'(ADDR_DATA));
        lock_wr      = acc_write && (acc_addr == ADDR_W'(ADDR_LOCK));
        status_wr    = acc_write && (acc_addr == ADDR_W'(ADDR_STATUS));
        data_allowed = (owner_q == OWN_FREE) || (owner_q == acc_owner);
        // Refused DATA write, or LOCK command from the port that does not own it
        conflict_inc = (data_wr && !data_allowed) ||
                       (lock_wr && owner_q != OWN_FREE && owner_q != acc_owner);
    end

    // Register read mux; zero latency, returned only to the granted port
    always_comb begin
        rd_value = '0;
        case (acc_addr)
            ADDR_W'(ADDR_DATA):   rd_value = data_q;
            ADDR_W'(ADDR_LOCK):   rd_value[1:0] = owner_q;
            ADDR_W'(ADDR_STATUS): rd_value[CNT_W-1:0] = conflict_q;
            default:              rd_value = '0;
        endcase
    end

    assign port_a.readdata = grant[PORT_A] ? rd_value : '0;
    assign port_b.readdata = grant[PORT_B] ? rd_value : '0;

    // DATA register: written by the owner, or by anyone while the lock is free
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here is a plain flop with a reset value; there is no memory array to leave unreset.
        if (reset) begin
            data_q <= RESET_VALUE;
        end else if (data_wr && data_allowed) begin
            data_q <= acc_wdata;
        end
    end

    // Owner FSM: acquire from FREE, release only by the current owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_FREE;
        end else begin
            case (owner_q)
                OWN_FREE: begin
                    if (lock_wr && acc_wdata[LOCK_BIT]) begin
                        owner_q <= acc_owner;
                    end
                end
                OWN_A, OWN_B: begin
                    if (lock_wr && !acc_wdata[LOCK_BIT] && owner_q == acc_owner) begin
                        owner_q <= OWN_FREE;
                    end
                end
                default: owner_q <= OWN_FREE;
            endcase
        end
    end

    // Conflict counter: cleared by any STATUS write, otherwise saturating increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (status_wr) begin
            conflict_q <= '0;
        end else if (conflict_inc && conflict_q != {CNT_W{1'b1}}) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign pio_out = data_q;
endmodule
